// File: rtl/lsb_mem_port_pkg.sv
// Shared constants and types for the LSB-side memory port: access type
// codes, funct3 encodings, state encoding and the IO space selector.
package lsb_mem_port_pkg;

    localparam logic [6:0] LD_TYPE = 7'b0000011;
    localparam logic [6:0] S_TYPE  = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // IO space starts at 0x30000; the two selector bits come from there
    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam logic [1:0]  IO_SEL_CODE = IO_BASE[17:16];

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Number of bytes moved by an access of the given funct3
    function automatic logic [2:0] byte_count(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsb_mem_port_if.sv
// Request/response handshake between the LSB (master) and the memory
// port (slave).
interface lsb_mem_port_if #(
    parameter int ADDR_W = 32
);
    logic              in_lsb_ready;
    logic [2:0]        op_in;
    logic [6:0]        instr_type_in;
    logic [ADDR_W-1:0] data_addr_in;
    logic [31:0]       data_in;
    logic              welcome_lsb;
    logic              cache_ready;
    logic [6:0]        cache_instr_type;
    logic [31:0]       cache_data_out;

    modport master (
        output in_lsb_ready, op_in, instr_type_in, data_addr_in, data_in,
        input  welcome_lsb, cache_ready, cache_instr_type, cache_data_out
    );

    modport slave (
        input  in_lsb_ready, op_in, instr_type_in, data_addr_in, data_in,
        output welcome_lsb, cache_ready, cache_instr_type, cache_data_out
    );
endinterface

// File: rtl/lsb_mem_port_load_extend.sv
// Sign/zero extension of the assembled little-endian load bytes.
module lsb_mem_port_load_extend
    import lsb_mem_port_pkg::*;
(
    input  logic [31:0] result,
    input  logic [2:0]  funct3,
    output logic [31:0] ext
);

    // Select extension by access width and signedness
    always_comb begin
        ext = result;
        case (funct3)
            F3_B:    ext = {{24{result[7]}}, result[7:0]};
            F3_H:    ext = {{16{result[15]}}, result[15:0]};
            F3_BU:   ext = {24'h0, result[7:0]};
            F3_HU:   ext = {16'h0, result[15:0]};
            F3_W:    ext = result;
            default: ext = result;
        endcase
    end

endmodule

// File: rtl/lsb_mem_port.sv
// Responder for LSB data accesses: serialises one load/store into byte
// transfers on the byte-wide synchronous RAM bus and returns load data
// with a one-cycle completion pulse.
module lsb_mem_port
    import lsb_mem_port_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int IO_SEL_MSB = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rob_clear,
    lsb_mem_port_if.slave     lsb,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              io_buffer_full
);

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic [6:0]        type_reg;
    logic [31:0]       data_reg;
    logic [2:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              clr_reg, clr_next;

    logic [31:0] result;
    logic [31:0] result_ext;
    logic [2:0]  n_bytes;
    logic        accept;
    logic        io_space;
    logic        store_stall;
    logic        load_sample;

    assign n_bytes     = byte_count(op_reg);
    assign accept      = rdy && !rob_clear && lsb.in_lsb_ready && (state_reg == ST_IDLE)
                         && ((lsb.instr_type_in == LD_TYPE) || (lsb.instr_type_in == S_TYPE));
    // addr_reg always holds the byte currently on the bus
    assign io_space    = (addr_reg[IO_SEL_MSB -: 2] == IO_SEL_CODE);
    assign store_stall = io_space && io_buffer_full;
    // In LOAD, count c>0 means byte c-1 is on mem_din this cycle
    assign load_sample = (state_reg == ST_LOAD) && (cnt_reg != 3'd0);

    assign lsb.welcome_lsb      = (state_reg == ST_IDLE) && rdy && rst;
    assign lsb.cache_ready      = (state_reg == ST_DONE) && rdy && !rob_clear && !clr_reg;
    assign lsb.cache_instr_type = (state_reg == ST_DONE) ? type_reg : '0;
    assign lsb.cache_data_out   = ((state_reg == ST_DONE) && (type_reg == LD_TYPE)) ? result_ext : '0;

    assign mem_a    = addr_reg;
    assign mem_wr   = (state_reg == ST_STORE) && rdy && !store_stall;
    assign mem_dout = (state_reg == ST_STORE) ? data_reg[{cnt_reg[1:0], 3'b000} +: 8] : '0;

    // Next-state, byte counter and bus address sequencing
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        clr_next   = clr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = (lsb.instr_type_in == S_TYPE) ? ST_STORE : ST_LOAD;
                    cnt_next   = 3'd0;
                    addr_next  = lsb.data_addr_in;
                    clr_next   = 1'b0;
                end
            end
            ST_LOAD: begin
                if (rob_clear) begin
                    state_next = ST_IDLE;
                end else begin
                    if (cnt_reg < n_bytes) begin
                        cnt_next = cnt_reg + 3'd1;
                        if (cnt_reg < n_bytes - 3'd1) begin
                            addr_next = addr_reg + ADDR_W'(1);
                        end
                    end
                    if (cnt_reg == n_bytes) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_STORE: begin
                // A committed store always finishes; a flush only hides its completion
                if (rob_clear) begin
                    clr_next = 1'b1;
                end
                if (!store_stall) begin
                    if (cnt_reg == n_bytes - 3'd1) begin
                        state_next = ST_DONE;
                    end else begin
                        cnt_next  = cnt_reg + 3'd1;
                        addr_next = addr_reg + ADDR_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and request registers, frozen while rdy is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            clr_reg   <= 1'b0;
            op_reg    <= '0;
            type_reg  <= '0;
            data_reg  <= '0;
        end else if (rdy) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            clr_reg   <= clr_next;
            if (accept) begin
                op_reg   <= lsb.op_in;
                type_reg <= lsb.instr_type_in;
                data_reg <= lsb.data_in;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_res_byte
            logic [7:0] byte_reg;
            // Capture load byte gi when it appears on mem_din
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    byte_reg <= '0;
                end else if (rdy && load_sample && (cnt_reg == 3'(gi + 1))) begin
                    byte_reg <= mem_din;
                end
            end
            assign result[gi*8 +: 8] = byte_reg;
        end
    endgenerate

    lsb_mem_port_load_extend u_load_extend (
        .result (result),
        .funct3 (op_reg),
        .ext    (result_ext)
    );

endmodule

// File: tb/tb_lsb_mem_port.sv
// Directed bench for lsb_mem_port: loads, extension, stores, IO stall,
// flushes, global stall and reset.
module tb_lsb_mem_port;
    import lsb_mem_port_pkg::*;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        rob_clear;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    logic [7:0] ram [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    lsb_mem_port_if #(.ADDR_W(32)) lsb_bus ();

    lsb_mem_port #(.ADDR_W(32), .IO_SEL_MSB(17)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .rob_clear      (rob_clear),
        .lsb            (lsb_bus),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port shares the rdy clock enable with the responder
    always @(posedge clk) begin
        if (rdy) mem_din <= ram[mem_a[11:0]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [6:0] ty,
                         input logic [31:0] addr, input logic [31:0] data);
        lsb_bus.op_in         = op;
        lsb_bus.instr_type_in = ty;
        lsb_bus.data_addr_in  = addr;
        lsb_bus.data_in       = data;
        lsb_bus.in_lsb_ready  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; rdy = 1'b1; rob_clear = 1'b0; io_buffer_full = 1'b0;
        lsb_bus.in_lsb_ready = 1'b0; lsb_bus.op_in = '0; lsb_bus.instr_type_in = '0;
        lsb_bus.data_addr_in = '0; lsb_bus.data_in = '0;
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        step(); step();
        n_checks++; if (lsb_bus.welcome_lsb !== 1'b0) begin n_fail++; $display("FAIL reset_welcome: got %0b want 0", lsb_bus.welcome_lsb); end
        n_checks++; if (lsb_bus.cache_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %0b want 0", lsb_bus.cache_ready); end
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL reset_mem_wr: got %0b want 0", mem_wr); end
        n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %0h want 0", mem_a); end
        n_checks++; if (lsb_bus.cache_data_out !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %0h want 0", lsb_bus.cache_data_out); end
        n_checks++; if (lsb_bus.cache_instr_type !== 7'h0) begin n_fail++; $display("FAIL reset_type: got %0h want 0", lsb_bus.cache_instr_type); end
        rst = 1'b1;
        #1;
        n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL reset_release_welcome: got %0b want 1", lsb_bus.welcome_lsb); end
        rdy = 1'b0;
        #1;
        n_checks++; if (lsb_bus.welcome_lsb !== 1'b0) begin n_fail++; $display("FAIL rdy_low_welcome: got %0b want 0", lsb_bus.welcome_lsb); end
        rdy = 1'b1;
        step();
        $display("reset: done");
    endtask

    task automatic test_lw();
        logic exp_rdy;
        ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
        issue(F3_W, LD_TYPE, 32'h100, 32'h0);
        #1;
        n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL lw_accept_welcome: got %0b want 1", lsb_bus.welcome_lsb); end
        for (int j = 1; j <= 7; j++) begin
            step();
            exp_rdy = (j == 6);
            n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL lw_mem_wr c%0d: got %0b want 0", j, mem_wr); end
            if (j <= 4) begin
                n_checks++; if (mem_a !== 32'h100 + 32'(j - 1)) begin n_fail++; $display("FAIL lw_mem_a c%0d: got %0h want %0h", j, mem_a, 32'h100 + 32'(j - 1)); end
            end
            n_checks++; if (lsb_bus.cache_ready !== exp_rdy) begin n_fail++; $display("FAIL lw_ready c%0d: got %0b want %0b", j, lsb_bus.cache_ready, exp_rdy); end
            if (j == 6) begin
                n_checks++; if (lsb_bus.cache_data_out !== 32'h12345678) begin n_fail++; $display("FAIL lw_data: got %0h want 12345678", lsb_bus.cache_data_out); end
                n_checks++; if (lsb_bus.cache_instr_type !== LD_TYPE) begin n_fail++; $display("FAIL lw_type: got %0h want %0h", lsb_bus.cache_instr_type, LD_TYPE); end
                lsb_bus.in_lsb_ready = 1'b0;
            end
            if (j == 7) begin
                n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL lw_idle_welcome: got %0b want 1", lsb_bus.welcome_lsb); end
            end
        end
        $display("LW  addr=00000100 data=%08h", 32'h12345678);
    endtask

    task automatic test_load_extend();
        logic [2:0]  t_op   [5] = '{F3_B, F3_BU, F3_H, F3_HU, F3_W};
        logic [31:0] t_addr [5] = '{32'h200, 32'h200, 32'h204, 32'h204, 32'hFFFF_FFFE};
        logic [31:0] t_exp  [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8000, 32'h0000_8000, 32'h4433_2211};
        int n;
        int lat;
        logic exp_rdy;
        ram[12'h200] = 8'h80; ram[12'h201] = 8'h7F;
        ram[12'h204] = 8'h00; ram[12'h205] = 8'h80; ram[12'h206] = 8'hFF;
        ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;
        for (int i = 0; i < 5; i++) begin
            n   = (t_op[i][1:0] == 2'b00) ? 1 : (t_op[i][1:0] == 2'b01) ? 2 : 4;
            lat = n + 2;
            issue(t_op[i], LD_TYPE, t_addr[i], 32'h0);
            for (int j = 1; j <= lat + 1; j++) begin
                step();
                exp_rdy = (j == lat);
                if (j <= n) begin
                    n_checks++; if (mem_a !== t_addr[i] + 32'(j - 1)) begin n_fail++; $display("FAIL ld%0d_mem_a c%0d: got %0h want %0h", i, j, mem_a, t_addr[i] + 32'(j - 1)); end
                end
                n_checks++; if (lsb_bus.cache_ready !== exp_rdy) begin n_fail++; $display("FAIL ld%0d_ready c%0d: got %0b want %0b", i, j, lsb_bus.cache_ready, exp_rdy); end
                if (j == lat) begin
                    n_checks++; if (lsb_bus.cache_data_out !== t_exp[i]) begin n_fail++; $display("FAIL ld%0d_data: got %0h want %0h", i, lsb_bus.cache_data_out, t_exp[i]); end
                    lsb_bus.in_lsb_ready = 1'b0;
                end
                if (j == lat + 1) begin
                    n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL ld%0d_welcome: got %0b want 1", i, lsb_bus.welcome_lsb); end
                end
            end
            $display("LD  op=%03b addr=%08h data=%08h", t_op[i], t_addr[i], t_exp[i]);
        end
    endtask

    task automatic test_sw();
        logic [31:0] wdata = 32'hDEAD_BEEF;
        // Full IO buffer must not stall a RAM-space store
        io_buffer_full = 1'b1;
        issue(F3_W, S_TYPE, 32'h300, wdata);
        for (int j = 1; j <= 6; j++) begin
            step();
            if (j <= 4) begin
                n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL sw_mem_wr c%0d: got %0b want 1", j, mem_wr); end
                n_checks++; if (mem_a !== 32'h300 + 32'(j - 1)) begin n_fail++; $display("FAIL sw_mem_a c%0d: got %0h want %0h", j, mem_a, 32'h300 + 32'(j - 1)); end
                n_checks++; if (mem_dout !== wdata[8*(j-1) +: 8]) begin n_fail++; $display("FAIL sw_dout c%0d: got %0h want %0h", j, mem_dout, wdata[8*(j-1) +: 8]); end
                n_checks++; if (lsb_bus.cache_ready !== 1'b0) begin n_fail++; $display("FAIL sw_early_ready c%0d: got %0b want 0", j, lsb_bus.cache_ready); end
            end
            if (j == 5) begin
                n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL sw_done_wr: got %0b want 0", mem_wr); end
                n_checks++; if (lsb_bus.cache_ready !== 1'b1) begin n_fail++; $display("FAIL sw_ready: got %0b want 1", lsb_bus.cache_ready); end
                n_checks++; if (lsb_bus.cache_data_out !== 32'h0) begin n_fail++; $display("FAIL sw_data: got %0h want 0", lsb_bus.cache_data_out); end
                n_checks++; if (lsb_bus.cache_instr_type !== S_TYPE) begin n_fail++; $display("FAIL sw_type: got %0h want %0h", lsb_bus.cache_instr_type, S_TYPE); end
                lsb_bus.in_lsb_ready = 1'b0;
            end
            if (j == 6) begin
                n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL sw_welcome: got %0b want 1", lsb_bus.welcome_lsb); end
                n_checks++; if (mem_a !== 32'h303) begin n_fail++; $display("FAIL sw_mem_a_hold: got %0h want 303", mem_a); end
            end
        end
        io_buffer_full = 1'b0;
        $display("SW  addr=00000300 data=%08h", wdata);
    endtask

    task automatic test_io_stall();
        logic exp_wr;
        logic exp_rdy;
        issue(F3_B, S_TYPE, 32'h0003_0000, 32'h0000_00A5);
        for (int j = 1; j <= 6; j++) begin
            step();
            io_buffer_full = (j <= 3);
            #1;
            exp_wr  = (j == 4);
            exp_rdy = (j == 5);
            n_checks++; if (mem_wr !== exp_wr) begin n_fail++; $display("FAIL io_mem_wr c%0d: got %0b want %0b", j, mem_wr, exp_wr); end
            n_checks++; if (lsb_bus.cache_ready !== exp_rdy) begin n_fail++; $display("FAIL io_ready c%0d: got %0b want %0b", j, lsb_bus.cache_ready, exp_rdy); end
            if (j <= 4) begin
                n_checks++; if (mem_a !== 32'h0003_0000) begin n_fail++; $display("FAIL io_mem_a c%0d: got %0h want 30000", j, mem_a); end
            end
            if (j == 4) begin
                n_checks++; if (mem_dout !== 8'hA5) begin n_fail++; $display("FAIL io_dout: got %0h want a5", mem_dout); end
            end
            if (j == 5) lsb_bus.in_lsb_ready = 1'b0;
        end
        $display("SB  addr=00030000 data=a5 io_stall=3");
    endtask

    task automatic test_rob_clear();
        // Flush in the accept cycle: request dropped
        issue(F3_W, LD_TYPE, 32'h100, 32'h0);
        rob_clear = 1'b1;
        step();
        rob_clear = 1'b0;
        lsb_bus.in_lsb_ready = 1'b0;
        #1;
        n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL clr_accept_welcome: got %0b want 1", lsb_bus.welcome_lsb); end
        n_checks++; if (mem_a !== 32'h0003_0000) begin n_fail++; $display("FAIL clr_accept_mem_a: got %0h want 30000", mem_a); end
        $display("CLR accept-cycle flush");

        // Flush mid-load
        issue(F3_W, LD_TYPE, 32'h100, 32'h0);
        for (int j = 1; j <= 7; j++) begin
            step();
            if (j == 3) begin rob_clear = 1'b1; lsb_bus.in_lsb_ready = 1'b0; end
            if (j == 4) rob_clear = 1'b0;
            #1;
            n_checks++; if (lsb_bus.cache_ready !== 1'b0) begin n_fail++; $display("FAIL clr_ld_ready c%0d: got %0b want 0", j, lsb_bus.cache_ready); end
            n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL clr_ld_mem_wr c%0d: got %0b want 0", j, mem_wr); end
            if (j == 4) begin
                n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL clr_ld_idle: got %0b want 1", lsb_bus.welcome_lsb); end
            end
        end
        $display("CLR LW flushed at A+3");

        // Flush on a committed SH: both bytes still written, no completion
        issue(F3_H, S_TYPE, 32'h310, 32'h1234_BEEF);
        for (int j = 1; j <= 4; j++) begin
            step();
            if (j == 1) begin rob_clear = 1'b1; lsb_bus.in_lsb_ready = 1'b0; end
            if (j == 2) rob_clear = 1'b0;
            #1;
            if (j == 1) begin
                n_checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'hEF || mem_a !== 32'h310) begin n_fail++; $display("FAIL clr_sh_b0: got wr=%0b d=%0h a=%0h want 1 ef 310", mem_wr, mem_dout, mem_a); end
            end
            if (j == 2) begin
                n_checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'hBE || mem_a !== 32'h311) begin n_fail++; $display("FAIL clr_sh_b1: got wr=%0b d=%0h a=%0h want 1 be 311", mem_wr, mem_dout, mem_a); end
            end
            if (j >= 3) begin
                n_checks++; if (lsb_bus.cache_ready !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL clr_sh_ready c%0d: got rdy=%0b wr=%0b want 0 0", j, lsb_bus.cache_ready, mem_wr); end
            end
            if (j == 4) begin
                n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL clr_sh_welcome: got %0b want 1", lsb_bus.welcome_lsb); end
            end
        end
        $display("CLR SH flushed at A+1");

        // Flush during DONE hides the pulse
        issue(F3_B, LD_TYPE, 32'h200, 32'h0);
        for (int j = 1; j <= 4; j++) begin
            step();
            if (j == 3) begin rob_clear = 1'b1; lsb_bus.in_lsb_ready = 1'b0; end
            if (j == 4) rob_clear = 1'b0;
            #1;
            n_checks++; if (lsb_bus.cache_ready !== 1'b0) begin n_fail++; $display("FAIL clr_done_ready c%0d: got %0b want 0", j, lsb_bus.cache_ready); end
            if (j == 4) begin
                n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL clr_done_welcome: got %0b want 1", lsb_bus.welcome_lsb); end
            end
        end
        $display("CLR LB flushed in DONE");
    endtask

    task automatic test_rdy_stall();
        logic [31:0] exp_a [6] = '{32'h100, 32'h101, 32'h101, 32'h101, 32'h102, 32'h103};
        logic exp_rdy;
        issue(F3_W, LD_TYPE, 32'h100, 32'h0);
        for (int j = 1; j <= 9; j++) begin
            step();
            rdy = !(j == 2 || j == 3);
            #1;
            exp_rdy = (j == 8);
            if (j <= 6) begin
                n_checks++; if (mem_a !== exp_a[j-1]) begin n_fail++; $display("FAIL stall_mem_a c%0d: got %0h want %0h", j, mem_a, exp_a[j-1]); end
            end
            n_checks++; if (lsb_bus.cache_ready !== exp_rdy) begin n_fail++; $display("FAIL stall_ready c%0d: got %0b want %0b", j, lsb_bus.cache_ready, exp_rdy); end
            if (j == 8) begin
                n_checks++; if (lsb_bus.cache_data_out !== 32'h12345678) begin n_fail++; $display("FAIL stall_data: got %0h want 12345678", lsb_bus.cache_data_out); end
                lsb_bus.in_lsb_ready = 1'b0;
            end
            if (j == 9) begin
                n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL stall_welcome: got %0b want 1", lsb_bus.welcome_lsb); end
            end
        end
        $display("LW  addr=00000100 rdy_low=2 data=12345678");

        issue(F3_B, S_TYPE, 32'h320, 32'h0000_005A);
        for (int j = 1; j <= 5; j++) begin
            step();
            rdy = !(j == 1 || j == 3);
            #1;
            if (j == 1) begin
                n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL stall_sb_wr_frozen: got %0b want 0", mem_wr); end
            end
            if (j == 2) begin
                n_checks++; if (mem_wr !== 1'b1 || mem_dout !== 8'h5A) begin n_fail++; $display("FAIL stall_sb_write: got wr=%0b d=%0h want 1 5a", mem_wr, mem_dout); end
            end
            if (j == 3) begin
                n_checks++; if (lsb_bus.cache_ready !== 1'b0) begin n_fail++; $display("FAIL stall_sb_ready_held: got %0b want 0", lsb_bus.cache_ready); end
            end
            if (j == 4) begin
                n_checks++; if (lsb_bus.cache_ready !== 1'b1) begin n_fail++; $display("FAIL stall_sb_ready: got %0b want 1", lsb_bus.cache_ready); end
                lsb_bus.in_lsb_ready = 1'b0;
            end
            if (j == 5) begin
                n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL stall_sb_welcome: got %0b want 1", lsb_bus.welcome_lsb); end
            end
        end
        $display("SB  addr=00000320 data=5a rdy_low=2");
    endtask

    task automatic test_reset_mid_sw();
        issue(F3_W, S_TYPE, 32'h300, 32'hDEAD_BEEF);
        step();
        n_checks++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL rst_sw_b0: got %0b want 1", mem_wr); end
        step();
        n_checks++; if (mem_wr !== 1'b1 || mem_a !== 32'h301) begin n_fail++; $display("FAIL rst_sw_b1: got wr=%0b a=%0h want 1 301", mem_wr, mem_a); end
        rst = 1'b0;
        lsb_bus.in_lsb_ready = 1'b0;
        #1;
        n_checks++; if (mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_mem_wr: got %0b want 0", mem_wr); end
        n_checks++; if (mem_a !== 32'h0) begin n_fail++; $display("FAIL rst_mid_mem_a: got %0h want 0", mem_a); end
        n_checks++; if (mem_dout !== 8'h0) begin n_fail++; $display("FAIL rst_mid_dout: got %0h want 0", mem_dout); end
        n_checks++; if (lsb_bus.welcome_lsb !== 1'b0) begin n_fail++; $display("FAIL rst_mid_welcome: got %0b want 0", lsb_bus.welcome_lsb); end
        n_checks++; if (lsb_bus.cache_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready: got %0b want 0", lsb_bus.cache_ready); end
        step();
        rst = 1'b1;
        #1;
        n_checks++; if (lsb_bus.welcome_lsb !== 1'b1) begin n_fail++; $display("FAIL rst_release_idle: got %0b want 1", lsb_bus.welcome_lsb); end
        for (int j = 0; j < 3; j++) begin
            step();
            n_checks++; if (lsb_bus.cache_ready !== 1'b0 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL rst_no_resume c%0d: got rdy=%0b wr=%0b want 0 0", j, lsb_bus.cache_ready, mem_wr); end
        end
        $display("SW  addr=00000300 reset mid-access");
    endtask

    initial begin
        test_reset();
        test_lw();
        test_load_extend();
        test_sw();
        test_io_stall();
        test_rob_clear();
        test_rdy_stall();
        test_reset_mid_sw();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
